fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 147 ++++++++++++++
 tb/tb_fwd_scoreboard.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks the results of the last DEPTH instructions that left EX
// and forwards them to NREAD operand read ports with zero latency. A matching
// load whose data has not returned yet raises stall.
//
// Optional feature: define FWD_STALL_COUNT_EN to add a saturating 32-bit
// stall_count output that counts cycles with stall=1 (cleared by rst_n only).
//
// Issue/stall contract: an instruction is accepted into the tracker on a rising
// edge where issue_valid=1, stall=0 and flush=0. While stall=1 the issue inputs
// are ignored and the tracked entries hold, so the upstream stage must keep the
// same instruction presented. op_data/fwd_hit are only meaningful when stall=0.
module fwd_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREAD = 2,
    parameter int DEPTH = 2,
    parameter int AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic                  issue_wen,
    input  logic [AW-1:0]         issue_rd,
    input  logic                  issue_is_load,
    input  logic [XLEN-1:0]       ex_result,
    input  logic                  mem_data_valid,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  flush,
    input  logic [NREAD-1:0]      rs_en,
    input  logic [NREAD*AW-1:0]   rs_addr,
    input  logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD*XLEN-1:0] op_data,
    output logic [NREAD-1:0]      fwd_hit,
    output logic                  stall
`ifdef FWD_STALL_COUNT_EN
    ,
    output logic [31:0]           stall_count
`endif
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage; index 0 is the youngest result.
    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_ready;
    logic [AW-1:0]    e_rd   [DEPTH];
    logic [XLEN-1:0]  e_data [DEPTH];

    logic [NREAD-1:0] port_stall;
    logic             cap_hit;
    logic [IW-1:0]    cap_idx;

    for (genvar g = 0; g < NREAD; g++) begin : g_port
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] reg_val;
        logic            hit;
        logic            hit_ready;
        logic [XLEN-1:0] hit_data;
        logic            active;

        assign addr    = rs_addr[g*AW +: AW];
        assign reg_val = rs_data[g*XLEN +: XLEN];

        // Scan oldest to youngest so the lowest-index (youngest) match wins.
        always_comb begin
            hit       = 1'b0;
            hit_ready = 1'b0;
            hit_data  = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (e_valid[k] && (e_rd[k] == addr)) begin
                    hit       = 1'b1;
                    hit_ready = e_ready[k];
                    hit_data  = e_data[k];
                end
            end
        end

        // x0 is never forwarded; a disabled port never forwards or stalls.
        assign active         = rs_en[g] && (addr != '0) && hit;
        assign port_stall[g]  = active && !hit_ready && !mem_data_valid;
        assign fwd_hit[g]     = active && (hit_ready || mem_data_valid);
        assign op_data[g*XLEN +: XLEN] = !active  ? reg_val  :
                                         hit_ready ? hit_data : mem_data;
    end

    assign stall = |port_stall;

    // Locate the youngest valid entry still waiting for load data.
    always_comb begin
        cap_hit = 1'b0;
        cap_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (e_valid[k] && !e_ready[k]) begin
                cap_hit = 1'b1;
                cap_idx = IW'(k);
            end
        end
    end

    // Entry update: reset, then flush, then stall-hold with capture, else shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_valid <= '0;
            e_ready <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                e_rd[k]   <= '0;
                e_data[k] <= '0;
            end
        end else if (flush) begin
            e_valid <= '0;
            e_ready <= '0;
        end else if (stall) begin
            if (mem_data_valid && cap_hit) begin
                e_data[cap_idx]  <= mem_data;
                e_ready[cap_idx] <= 1'b1;
            end
        end else begin
            // The oldest entry falls off the end: it is in the register file now.
            for (int k = 1; k < DEPTH; k++) begin
                e_valid[k] <= e_valid[k-1];
                e_rd[k]    <= e_rd[k-1];
                if (e_valid[k-1] && !e_ready[k-1] && mem_data_valid) begin
                    e_data[k]  <= mem_data;
                    e_ready[k] <= 1'b1;
                end else begin
                    e_data[k]  <= e_data[k-1];
                    e_ready[k] <= e_ready[k-1];
                end
            end
            e_valid[0] <= issue_valid && issue_wen && (issue_rd != '0);
            e_rd[0]    <= issue_rd;
            e_data[0]  <= ex_result;
            e_ready[0] <= !issue_is_load;
        end
    end

`ifdef FWD_STALL_COUNT_EN
    // Saturating count of stalled cycles; flush does not clear it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: expected operands are queued when a read is
// driven and popped when the combinational result is sampled mid-cycle.
module tb_fwd_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREAD = 2;
    localparam int DEPTH = 2;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  issue_valid;
    logic                  issue_wen;
    logic [AW-1:0]         issue_rd;
    logic                  issue_is_load;
    logic [XLEN-1:0]       ex_result;
    logic                  mem_data_valid;
    logic [XLEN-1:0]       mem_data;
    logic                  flush;
    logic [NREAD-1:0]      rs_en;
    logic [NREAD*AW-1:0]   rs_addr;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD*XLEN-1:0] op_data;
    logic [NREAD-1:0]      fwd_hit;
    logic                  stall;
`ifdef FWD_STALL_COUNT_EN
    logic [31:0]           stall_count;
`endif

    logic [XLEN-1:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    fwd_scoreboard #(.XLEN(XLEN), .NREAD(NREAD), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_wen      (issue_wen),
        .issue_rd       (issue_rd),
        .issue_is_load  (issue_is_load),
        .ex_result      (ex_result),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .flush          (flush),
        .rs_en          (rs_en),
        .rs_addr        (rs_addr),
        .rs_data        (rs_data),
        .op_data        (op_data),
        .fwd_hit        (fwd_hit),
        .stall          (stall)
`ifdef FWD_STALL_COUNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        issue_valid    = 1'b0;
        issue_wen      = 1'b0;
        issue_rd       = '0;
        issue_is_load  = 1'b0;
        ex_result      = '0;
        mem_data_valid = 1'b0;
        mem_data       = '0;
        flush          = 1'b0;
        rs_en          = '0;
        rs_addr        = '0;
        rs_data        = '0;
    endtask

    task automatic set_issue(input logic [AW-1:0] rd, input logic [XLEN-1:0] val,
                             input logic ld);
        issue_valid   = 1'b1;
        issue_wen     = 1'b1;
        issue_rd      = rd;
        ex_result     = val;
        issue_is_load = ld;
    endtask

    task automatic set_read(input int j, input logic en, input logic [AW-1:0] a,
                            input logic [XLEN-1:0] d);
        rs_en[j]               = en;
        rs_addr[j*AW +: AW]    = a;
        rs_data[j*XLEN +: XLEN] = d;
    endtask

    // Advance to the falling edge and clear all stimulus for the new cycle.
    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [XLEN-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input int j);
        logic [XLEN-1:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            n_fail++;
            $display("FAIL %s: observed %0h expected <queue empty>", tag,
                     op_data[j*XLEN +: XLEN]);
        end else begin
            e = exp_q.pop_front();
            chk(tag, op_data[j*XLEN +: XLEN], e);
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state: no forwarding, no stall, operands from register file.
        set_read(0, 1'b1, 5'd5, 32'hA5A5_A5A5); sb_push(32'hA5A5_A5A5);
        set_read(1, 1'b1, 5'd3, 32'h5A5A_5A5A); sb_push(32'h5A5A_5A5A);
        #1;
        chk("rst_stall", XLEN'(stall), 0);
        chk("rst_hit", XLEN'(fwd_hit), 0);
        sb_check("rst_op0", 0);
        sb_check("rst_op1", 1);
`ifdef FWD_STALL_COUNT_EN
        chk("rst_count", stall_count, 0);
`endif

        // Single ALU result forwarded the next cycle; disabled port ignored.
        next_cycle();
        set_issue(5'd5, 32'h11, 1'b0);
        next_cycle();
        set_read(0, 1'b1, 5'd5, 32'h99); sb_push(32'h11);
        set_read(1, 1'b0, 5'd5, 32'h77); sb_push(32'h77);
        #1;
        sb_check("fwd_op0", 0);
        sb_check("dis_op1", 1);
        chk("fwd_hit", XLEN'(fwd_hit), 1);
        chk("fwd_stall", XLEN'(stall), 0);

        // Two writes to x3: the youngest wins; x5 has aged out.
        next_cycle();
        set_issue(5'd3, 32'hA, 1'b0);
        next_cycle();
        set_issue(5'd3, 32'hB, 1'b0);
        next_cycle();
        set_read(0, 1'b1, 5'd3, 32'h33); sb_push(32'hB);
        set_read(1, 1'b1, 5'd3, 32'h34); sb_push(32'hB);
        #1;
        sb_check("young_op0", 0);
        sb_check("young_op1", 1);
        chk("young_hit", XLEN'(fwd_hit), 3);
        next_cycle();
        set_read(0, 1'b1, 5'd3, 32'h33); sb_push(32'hB);
        set_read(1, 1'b1, 5'd5, 32'h55); sb_push(32'h55);
        #1;
        sb_check("old_op0", 0);
        sb_check("drop_op1", 1);
        chk("old_hit", XLEN'(fwd_hit), 1);

        // Load-use: stall until data returns, then forward mem_data.
        next_cycle();
        set_issue(5'd7, 32'h1234, 1'b1);
        next_cycle();
        set_read(0, 1'b1, 5'd7, 32'h70);
        #1;
        chk("lu_stall1", XLEN'(stall), 1);
        next_cycle();
        set_read(0, 1'b1, 5'd7, 32'h70); sb_push(32'hDEAD);
        mem_data_valid = 1'b1;
        mem_data       = 32'hDEAD;
        #1;
        sb_check("lu_op0", 0);
        chk("lu_hit", XLEN'(fwd_hit), 1);
        chk("lu_stall0", XLEN'(stall), 0);
        // The returning data was captured while the entry shifted.
        next_cycle();
        set_read(0, 1'b1, 5'd7, 32'h70); sb_push(32'hDEAD);
        #1;
        sb_check("lu_cap_op0", 0);
        chk("lu_cap_stall", XLEN'(stall), 0);

        // Writes to x0 are never tracked.
        next_cycle();
        set_issue(5'd0, 32'h55, 1'b0);
        next_cycle();
        set_read(0, 1'b1, 5'd0, 32'h0); sb_push(32'h0);
        #1;
        sb_check("x0_op0", 0);
        chk("x0_hit", XLEN'(fwd_hit), 0);

        // Flush beats a same-cycle load return.
        next_cycle();
        set_issue(5'd9, 32'h9999, 1'b1);
        next_cycle();
        flush          = 1'b1;
        mem_data_valid = 1'b1;
        mem_data       = 32'hBEEF;
        next_cycle();
        set_read(0, 1'b1, 5'd9, 32'h909); sb_push(32'h909);
        #1;
        sb_check("flush_op0", 0);
        chk("flush_stall", XLEN'(stall), 0);
        chk("flush_hit", XLEN'(fwd_hit), 0);

        // Fresh reset, then three stalled cycles, then reset during the stall.
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        set_issue(5'd4, 32'h4444, 1'b1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_read(0, 1'b1, 5'd4, 32'h40);
            #1;
            chk($sformatf("rs_stall%0d", i), XLEN'(stall), 1);
        end
        next_cycle();
        set_read(0, 1'b1, 5'd4, 32'h40);
`ifdef FWD_STALL_COUNT_EN
        #1;
        chk("count3", stall_count, 3);
`endif
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        set_read(0, 1'b1, 5'd4, 32'h40); sb_push(32'h40);
        #1;
        chk("rs_stall_end", XLEN'(stall), 0);
        chk("rs_hit", XLEN'(fwd_hit), 0);
        sb_check("rs_op0", 0);
`ifdef FWD_STALL_COUNT_EN
        chk("count0", stall_count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
